// File: rtl/gpio_out_pkg.sv
// Shared types and helpers for the GPIO output stage: channel mode encodings
// and the counter-width helper used by the stretch and watchdog counters.
package gpio_out_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_INV     = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_OFF     = 2'b11
  } cfg_mode_t;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gpio_out_chan.sv
// One output channel: 2-FF synchroniser, mode register, pulse-stretch counter
// and the registered pin driver with safe-level override.
module gpio_out_chan
  import gpio_out_pkg::*;
#(
  parameter int        STRETCH    = 8,
  parameter logic      SAFE_BIT   = 1'b0,
  parameter cfg_mode_t RESET_MODE = MODE_PASS
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      io_in,
  input  logic      mode_we,
  input  cfg_mode_t mode_wdata,
  input  logic      trip_d,
  output logic      io_out
);

  localparam int CW = cnt_width(STRETCH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH - 1);

  logic          sync1_q, sync1_d;
  logic          s_in_q, s_in_d;
  logic          s_prev_q, s_prev_d;
  cfg_mode_t     mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise;

  always_comb begin
    sync1_d  = io_in;
    s_in_d   = sync1_q;
    s_prev_d = s_in_q;
    rise     = s_in_q & ~s_prev_q;
    mode_d   = mode_we ? mode_wdata : mode_q;

    // A mode write wins over a rising edge so the new mode starts clean.
    cnt_d = '0;
    if (!mode_we && (mode_q == MODE_STRETCH)) begin
      if (rise) begin
        cnt_d = CNT_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    case (mode_q)
      MODE_PASS:    out_d = s_in_q;
      MODE_INV:     out_d = ~s_in_q;
      MODE_STRETCH: out_d = s_in_q | (cnt_q != '0);
      default:      out_d = SAFE_BIT;
    endcase

    // Using the next trip state makes the pin go safe on the same edge
    // that WDT_TRIP rises.
    if (trip_d) begin
      out_d = SAFE_BIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      s_in_q   <= 1'b0;
      s_prev_q <= 1'b0;
      mode_q   <= RESET_MODE;
      cnt_q    <= '0;
      out_q    <= SAFE_BIT;
    end else begin
      sync1_q  <= sync1_d;
      s_in_q   <= s_in_d;
      s_prev_q <= s_prev_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign io_out = out_q;

endmodule

// File: rtl/gpio_out_ctrl.sv
// STM32-to-connector output stage: per-channel conditioning plus a heartbeat
// watchdog that forces every pin to its safe level when the heartbeat stalls.
module gpio_out_ctrl
  import gpio_out_pkg::*;
#(
  parameter int             N          = 9,
  parameter int             STRETCH    = 8,
  parameter int             WDT_CYCLES = 1000000,
  parameter logic [N-1:0]   SAFE_VAL   = '0,
  parameter cfg_mode_t      RESET_MODE = MODE_PASS,
  localparam int            CH_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    IO_IN,
  output logic [N-1:0]    IO_OUT,
  input  logic            CFG_WE,
  input  logic [CH_W-1:0] CFG_CH,
  input  logic [1:0]      CFG_MODE,
  input  logic            HB,
  output logic            WDT_TRIP
);

  localparam int WDT_W = cnt_width(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES);

  logic             hb1_q, hb1_d;
  logic             s_hb_q, s_hb_d;
  logic             hb_prev_q, hb_prev_d;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             trip_q, trip_d;
  logic             hb_edge;
  cfg_mode_t        cfg_mode;

  assign cfg_mode = cfg_mode_t'(CFG_MODE);

  always_comb begin
    hb1_d     = HB;
    s_hb_d    = hb1_q;
    hb_prev_d = s_hb_q;
    hb_edge   = s_hb_q ^ hb_prev_q;
    wdt_cnt_d = wdt_cnt_q;
    trip_d    = trip_q;

    // A heartbeat edge on the timeout cycle takes priority, so no trip.
    if (WDT_CYCLES == 0) begin
      wdt_cnt_d = '0;
      trip_d    = 1'b0;
    end else if (hb_edge) begin
      wdt_cnt_d = '0;
      trip_d    = 1'b0;
    end else begin
      if (wdt_cnt_q != WDT_MAX) begin
        wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end
      if (wdt_cnt_d == WDT_MAX) begin
        trip_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hb1_q     <= 1'b0;
      s_hb_q    <= 1'b0;
      hb_prev_q <= 1'b0;
      wdt_cnt_q <= '0;
      trip_q    <= 1'b0;
    end else begin
      hb1_q     <= hb1_d;
      s_hb_q    <= s_hb_d;
      hb_prev_q <= hb_prev_d;
      wdt_cnt_q <= wdt_cnt_d;
      trip_q    <= trip_d;
    end
  end

  assign WDT_TRIP = trip_q;

  // Channel indices at or above N match no instance and are dropped.
  for (genvar i = 0; i < N; i++) begin : g_chan
    gpio_out_chan #(
      .STRETCH    (STRETCH),
      .SAFE_BIT   (SAFE_VAL[i]),
      .RESET_MODE (RESET_MODE)
    ) u_chan (
      .clk        (CLK),
      .rst        (RST),
      .io_in      (IO_IN[i]),
      .mode_we    (CFG_WE && (CFG_CH == CH_W'(i))),
      .mode_wdata (cfg_mode),
      .trip_d     (trip_d),
      .io_out     (IO_OUT[i])
    );
  end

endmodule

// File: doc/gpio_out_ctrl.md
# gpio_out_ctrl

Parametrised STM32-to-connector output stage for the CPLD: N channels from the STM32 are synchronised, conditioned by a per-channel mode (pass, invert, pulse-stretch, forced-safe) and registered onto the connector pins. A heartbeat watchdog drives every pin to a safe level if the STM32 stops toggling its heartbeat line. It replaces plain wire-through output mapping wherever outputs must be clean, configurable and fail-safe.

## Interface
- N, 9: channel count (1..16)
- STRETCH, 8: minimum high time, in CLK cycles, for stretch mode (≥1)
- WDT_CYCLES, 1000000: heartbeat timeout in CLK cycles; 0 disables the watchdog
- SAFE_VAL, {N{1'b0}}: pin levels forced in safe mode and after reset
- RESET_MODE, 2'b00: mode loaded into every channel at reset

- CLK  in  1  system clock; one clock domain
- RST  in  1  reset, synchronous and active-high
- IO_IN  in  N  STM32 output levels, asynchronous to CLK
- IO_OUT  out  N  connector pin levels, registered
- CFG_WE  in  1  write strobe, sampled on CLK, one write per asserted cycle
- CFG_CH  in  $clog2(N)  channel index for the write
- CFG_MODE  in  2  mode: 00 pass, 01 invert, 10 stretch, 11 off
- HB  in  1  STM32 heartbeat, asynchronous; any edge counts
- WDT_TRIP  out  1  high while the watchdog holds the outputs safe

## Operation
- Each IO_IN bit and HB pass through a 2-FF synchroniser; all logic uses the synchronised values (s_in, s_hb).
- Per-channel 2-bit mode register. On CFG_WE with CFG_CH < N, mode[CFG_CH] := CFG_MODE. CFG_CH ≥ N is ignored.
- Pass: next IO_OUT[i] = s_in[i]. Invert: next = ~s_in[i]. Off: next = SAFE_VAL[i].
- Stretch: per-channel counter, $clog2(STRETCH+1) bits. A rising edge of s_in[i] loads STRETCH−1. The counter decrements to 0 and saturates there. Output = s_in[i] OR (counter ≠ 0), so a pulse is never shorter than STRETCH cycles and a long pulse is unchanged. A rising edge during an active count reloads the counter.
- A mode write to a channel clears that channel's stretch counter in the same cycle.
- Watchdog: counter cleared on every s_hb edge, otherwise incremented and saturating at WDT_CYCLES. Reaching WDT_CYCLES sets WDT_TRIP.
  - While WDT_TRIP is high, IO_OUT = SAFE_VAL regardless of mode.
  - The next s_hb edge clears WDT_TRIP and the counter; normal outputs resume the following cycle.
  - Mode writes are still accepted while tripped.
- Reset: IO_OUT = SAFE_VAL, WDT_TRIP = 0, all modes = RESET_MODE, all counters and synchroniser flops = 0. Reset applied mid-stretch or mid-trip aborts the activity immediately.

## Timing
- IO_IN → IO_OUT latency is 3 CLK edges in pass/invert mode: 2 synchroniser stages plus the output register. HB → watchdog clear has the same 2-cycle synchroniser delay.
- Stretch: a 1-cycle s_in pulse gives IO_OUT high for exactly STRETCH cycles, starting 3 edges after IO_IN rises.
- A mode write at edge k affects the IO_OUT value registered at edge k+1.
- If a CFG_WE write and a trip occur in the same cycle, both take effect; the trip masks the output.
- If an HB edge and the timeout occur in the same cycle, the HB edge wins and no trip occurs.
- WDT_TRIP is registered and rises on the same edge that IO_OUT switches to SAFE_VAL.

## Structure
- Package gpio_out_pkg: mode encodings MODE_PASS, MODE_INV, MODE_STRETCH, MODE_OFF, and the cfg_mode_t 2-bit typedef.
- Sub-module gpio_out_chan, instantiated N times via generate: one synchroniser, mode register, stretch counter and output flop per channel.
- Top level holds the watchdog, the HB synchroniser, the CFG decode and the safe-mode override.

## Test plan
- Reset, then N=9 in pass mode: drive IO_IN=9'h155 → IO_OUT=9'h155 on the 3rd edge; IO_OUT=SAFE_VAL (0) during reset.
- Write ch3 to invert and ch5 to off, then IO_IN=9'h1FF → IO_OUT=9'h1D7. Write with CFG_CH=12 → no mode changes.
- Ch0 in stretch with STRETCH=8: 1-cycle pulse → 8 high cycles. 20-cycle pulse → 20 high cycles. Second pulse 4 cycles into the count → high for 4+8 cycles total.
- WDT_CYCLES=50 with HB held static → WDT_TRIP rises and IO_OUT=SAFE_VAL at cycle 50. A single HB toggle → trip clears and pass-mode outputs return 1 cycle after the synchronised edge.
- HB edge landing exactly on the timeout cycle → no trip. Assert RST during an active stretch and an active trip → outputs=SAFE_VAL, WDT_TRIP=0, modes=RESET_MODE next edge.
